// File: rtl/rot_pkg.sv
// Shared types and constants for the rotation-amount detector.
// The optional masked compare is enabled by defining MATCH_MASK_EN.
package rot_pkg;

    localparam int W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } rot_state_e;

endpackage

// File: rtl/rot_match_cmp.sv
// Combinational W-bit equality between the rotated work word and the target.
// With MATCH_MASK_EN defined, only bit positions with m=1 take part.
module rot_match_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef MATCH_MASK_EN
    input  logic [W-1:0] m,
`endif
    output logic         eq
);

    // Bitwise difference, optionally gated by the compare mask
    always_comb begin
`ifdef MATCH_MASK_EN
        eq = (((a ^ b) & m) == {W{1'b0}});
`else
        eq = ((a ^ b) == {W{1'b0}});
`endif
    end

endmodule

// File: rtl/rot_amt_detect.sv
// Finds the smallest right-rotate amount k with rotr(a,k) == y by stepping one rotation per cycle.
// Defining MATCH_MASK_EN adds a per-bit compare mask latched alongside a and y.
module rot_amt_detect
    import rot_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         y,
`ifdef MATCH_MASK_EN
    input  logic [W-1:0]         mask,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic [$clog2(W)-1:0] amt
);

    localparam int AW = $clog2(W);
    localparam logic [AW-1:0] LAST_AMT = AW'(W - 1);

    rot_state_e    state_r;
    rot_state_e    state_nxt_s;
    logic [W-1:0]  work_r;
    logic [W-1:0]  y_r;
    logic [AW-1:0] count_r;
    logic [AW-1:0] amt_r;
    logic          found_r;
    logic          busy_r;
    logic          done_r;
    logic          match_s;
`ifdef MATCH_MASK_EN
    logic [W-1:0]  mask_r;
`endif

    function automatic logic [W-1:0] rotr1(input logic [W-1:0] v);
        return {v[0], v[W-1:1]};
    endfunction

    rot_match_cmp #(.W(W)) u_cmp (
        .a  (work_r),
        .b  (y_r),
`ifdef MATCH_MASK_EN
        .m  (mask_r),
`endif
        .eq (match_s)
    );

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = SEARCH;
                else       state_nxt_s = IDLE;
            end
            SEARCH: begin
                if (match_s || (count_r == LAST_AMT)) state_nxt_s = DONE;
                else                                  state_nxt_s = SEARCH;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and registered status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == SEARCH);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Operand capture, rotation walk and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work_r  <= {W{1'b0}};
            y_r     <= {W{1'b0}};
            count_r <= {AW{1'b0}};
            amt_r   <= {AW{1'b0}};
            found_r <= 1'b0;
`ifdef MATCH_MASK_EN
            mask_r  <= {W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        work_r  <= a;
                        y_r     <= y;
                        count_r <= {AW{1'b0}};
                        amt_r   <= {AW{1'b0}};
                        found_r <= 1'b0;
`ifdef MATCH_MASK_EN
                        mask_r  <= mask;
`endif
                    end
                end
                SEARCH: begin
                    if (match_s) begin
                        amt_r   <= count_r;
                        found_r <= 1'b1;
                    end else if (count_r == LAST_AMT) begin
                        amt_r   <= {AW{1'b0}};
                        found_r <= 1'b0;
                    end else begin
                        work_r  <= rotr1(work_r);
                        count_r <= count_r + AW'(1'b1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign found = found_r;
    assign amt   = amt_r;

endmodule

// File: tb/tb_rot_amt_detect.sv
// Scoreboard bench for rot_amt_detect at W=8: stimulus pushes expected results, a monitor checks each done pulse.
// Mask vectors run only when MATCH_MASK_EN is defined.
module tb_rot_amt_detect;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] y = 8'h00;
    logic [7:0] mask = 8'hFF;
    logic       busy;
    logic       done;
    logic       found;
    logic [2:0] amt;

    typedef struct {
        logic       found;
        logic [2:0] amt;
        int         lat;
        int         e0;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   busy_run = 0;
    int   checks   = 0;
    int   errors   = 0;

    rot_amt_detect #(.W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .y       (y),
`ifdef MATCH_MASK_EN
        .mask    (mask),
`endif
        .busy    (busy),
        .done    (done),
        .found   (found),
        .amt     (amt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", int'(done), 0);
            end else begin
                e = sb.pop_front();
                check("found", int'(found), int'(e.found));
                check("amt", int'(amt), int'(e.amt));
                check("latency", edge_cnt - e.e0, e.lat);
                check("busy_cycles", busy_run, e.lat);
            end
            busy_run = 0;
        end else if (busy === 1'b1) begin
            busy_run++;
        end else begin
            busy_run = 0;
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("timeout_pending", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic run(input logic [7:0] av, input logic [7:0] yv, input logic [7:0] mv,
                       input logic ef, input logic [2:0] ea, input int lat);
        @(negedge clk);
        a = av; y = yv; mask = mv; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{ef, ea, lat, edge_cnt});
        start = 1'b0;
        a = ~av; y = 8'h00; mask = 8'h00;
        check("clear_found_on_start", int'(found), 0);
        check("clear_amt_on_start", int'(amt), 0);
        wait_drain();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_found", int'(found), 0);
        check("rst_amt", int'(amt), 0);
        reset_n = 1'b1;

        // 0x96 rotated right by 3 is 0xD2; accepted on first edge after reset release
        run(8'h96, 8'hD2, 8'hFF, 1'b1, 3'd3, 4);
        // Identity match at k=0
        run(8'hB4, 8'hB4, 8'hFF, 1'b1, 3'd0, 1);
        // Different popcount: no rotation matches
        run(8'h01, 8'h03, 8'hFF, 1'b0, 3'd0, 8);

        // Periodic word: smallest k=1 wins; start held through SEARCH and DONE is ignored
        @(negedge clk);
        a = 8'hAA; y = 8'h55; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{1'b1, 3'd1, 2, edge_cnt});
        a = 8'h00; y = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("timeout_pending", sb.size(), 0);
        check("hold_found", int'(found), 1);
        check("hold_amt", int'(amt), 1);
        check("idle_busy", int'(busy), 0);

        // Abort a search with reset mid-flight; outputs clear without waiting for an edge
        @(negedge clk);
        a = 8'h01; y = 8'h80; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_found", int'(found), 0);
        check("abort_amt", int'(amt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        // rotr(0x01,7) = 0x02
        run(8'h01, 8'h02, 8'hFF, 1'b1, 3'd7, 8);

`ifdef MATCH_MASK_EN
        // Upper nibble only: rotr(0x12,4)=0x21 agrees with 0x20 there
        run(8'h12, 8'h20, 8'hF0, 1'b1, 3'd4, 5);
        // Empty mask matches immediately
        run(8'h12, 8'h20, 8'h00, 1'b1, 3'd0, 1);
`endif

        repeat (3) @(negedge clk);
        check("final_pending", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rot_amt_detect.md
ROT_AMT_DETECT -- requirements
Module: rot_amt_detect

Interface
REQ-001 SHALL have parameter: W, 8, data width; power of two, W >= 2; AW = log2(W) is derived, not a parameter.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request a search; sampled only in IDLE.
REQ-005 SHALL have port: a  input  W  unrotated reference word, latched when start is accepted.
REQ-006 SHALL have port: y  input  W  rotated target word, latched when start is accepted.
REQ-007 SHALL have port: mask  input  W  compare enable per bit, latched with a/y; present only with MATCH_MASK_EN.
REQ-008 SHALL have port: busy  output  1  high while searching.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking result valid.
REQ-010 SHALL have port: found  output  1  1 = a match was found.
REQ-011 SHALL have port: amt  output  AW  smallest right-rotate amount k with rotr(a,k) == y.

Function
REQ-012 SHALL implement FSM with states IDLE, SEARCH and DONE.
REQ-013 IDLE + start=1 SHALL latch a/y(/mask), clear count to 0, load the work register with a, and go to SEARCH.
REQ-014 SEARCH SHALL compare the work register with latched y each cycle, with count = current rotation amount.
REQ-015 On match in SEARCH: amt <= count, found <= 1, go to DONE.
REQ-016 On miss with count == W-1: amt <= 0, found <= 0, go to DONE.
REQ-017 On other miss: rotate the work register right by 1 (LSB into MSB), count += 1, stay in SEARCH.
REQ-018 DONE SHALL last exactly one cycle, assert done=1 and return to IDLE.
REQ-019 Latency: for a match at k, done SHALL be high in the cycle after edge E0+k+1 (E0 = edge sampling start); for no match, after edge E0+W.
REQ-020 busy SHALL be 1 exactly while in SEARCH.
REQ-021 start outside IDLE (SEARCH or DONE) SHALL be ignored; it SHALL NOT restart or queue a search.
REQ-022 amt/found SHALL hold their values from DONE until the next accepted start, and SHALL clear to 0 when start is accepted.
REQ-023 Input changes after start is accepted SHALL NOT affect the result in progress.
REQ-024 The smallest k SHALL win when several amounts match (periodic words).

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, found=0, amt=0, count=0 and the work register to 0, including mid-search.
REQ-026 The first start SHALL be accepted on the first rising edge with reset_n=1.

Configuration
REQ-027 SHALL use macro MATCH_MASK_EN: when defined, the mask port exists and the compare uses only bits where mask=1; an all-zero mask SHALL match at k=0.
REQ-028 When MATCH_MASK_EN is undefined, the mask port and mask register SHALL be absent and the compare SHALL be full W-bit equality.

Structure
REQ-029 Package rot_pkg SHALL hold the FSM state enum (IDLE, SEARCH, DONE) and the default width constant W_DEF=8.
REQ-030 Sub-module rot_match_cmp (combinational masked/unmasked W-bit equality) SHALL be instantiated once; no other sub-modules.

Verification (W=8)
REQ-031 Test: a=0x96, y=0xD2, start -> done at E0+4, found=1, amt=3; busy high for 4 cycles.
REQ-032 Test: a=0xB4, y=0xB4 -> done at E0+1, found=1, amt=0.
REQ-033 Test: a=0x01, y=0x03 -> done at E0+8, found=0, amt=0.
REQ-034 Test: a=0xAA, y=0x55 -> found=1, amt=1 (smallest of 1, 3, 5, 7); start pulsed during SEARCH is ignored, and done pulses exactly once.
REQ-035 Test: reset_n=0 for 1 cycle at E0+2 of the search a=0x01, y=0x80 -> outputs 0 at once; a new start after release -> found=1, amt=7.
REQ-036 Test, MATCH_MASK_EN only: a=0x12, y=0x20, mask=0xF0 -> found=1, amt=4; mask=0x00 -> amt=0.
